// File: rtl/dfi_rdlat_align.sv
// dfi_rdlat_align: DFI read-return aligner.
// Each phase's read enable is delayed by a programmable whole-cycle latency
// (rdlat) and rotated by a sub-cycle phase offset (rdphase). Raw pad data gets
// the same rotation and is returned to the controller with its aligned valid.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   dfi_rddata_en_i     per-phase read enable from the controller
//   phy_rddata_i        raw captured pad data, slice p = phase p
//   dfi_rddata_o        aligned read data, zero where valid is low
//   dfi_rddata_valid_o  aligned per-phase valid
//   csr_adr/csr_we/csr_dat_w/csr_dat_r  CSR bus, combinational read
//   err_o               sticky error (STATUS.err)
//
// Registers (byte offsets from CSR_BASE)
//   0x0 CTRL    [LW-1:0] rdlat (saturating), [10:8] rdphase, [31] flush (W1, reads 0)
//   0x4 STATUS  [0] busy (RO), [1] err (W1C)
//   0x8 STATS   delivered valid-phase count, only with DFI_RDLAT_STATS_EN
//
// Pad data is taken in the cycle its tap reaches the rotator, so it leaves the
// output register together with its valid.
//
// state  | meaning
// IDLE   | delay line empty, CTRL writes accepted
// ACTIVE | reads in flight, CTRL latency/phase writes rejected (err)
// FLUSH  | one cycle, clears delay line, prev registers and outputs
module dfi_rdlat_align #(
  parameter int         NPHASES  = 8,
  parameter int         DATA_W   = 32,
  parameter int         MAX_LAT  = 31,
  parameter logic [9:0] CSR_BASE = 10'h040
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPHASES-1:0]          dfi_rddata_en_i,
  input  logic [NPHASES*DATA_W-1:0]   phy_rddata_i,
  output logic [NPHASES*DATA_W-1:0]   dfi_rddata_o,
  output logic [NPHASES-1:0]          dfi_rddata_valid_o,
  input  logic [9:0]                  csr_adr,
  input  logic                        csr_we,
  input  logic [31:0]                 csr_dat_w,
  output logic [31:0]                 csr_dat_r,
  output logic                        err_o
);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int PW = (NPHASES > 1) ? $clog2(NPHASES) : 1;
  localparam int NW = NPHASES * DATA_W;
  localparam int SW = $clog2(2 * NW);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_FLUSH = 2'd2} state_t;
  state_t state_q, state_d;

  logic [LW-1:0]      rdlat_q;
  logic [PW-1:0]      rdphase_q;
  logic               err_q;
  logic [NPHASES-1:0] dline_q [MAX_LAT+1];
  logic [NPHASES-1:0] prev_v_q;
  logic [NW-1:0]      prev_d_q;
  logic               busy, clear_pipe, cfg_open, ovf;

  // CSR decode
  logic sel_ctrl, sel_status, wr_ctrl, wr_status, flush_req;
  assign sel_ctrl   = (csr_adr == CSR_BASE);
  assign sel_status = (csr_adr == CSR_BASE + 10'h004);
  assign wr_ctrl    = csr_we & sel_ctrl;
  assign wr_status  = csr_we & sel_status;
  assign flush_req  = wr_ctrl & csr_dat_w[31];

  logic unused_dat;
  assign unused_dat = ^csr_dat_w;

  logic [7:0]    lat_wr;
  logic [LW-1:0] lat_sat;
  assign lat_wr  = csr_dat_w[7:0];
  assign lat_sat = (lat_wr > 8'(MAX_LAT)) ? LW'(MAX_LAT) : lat_wr[LW-1:0];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|dfi_rddata_en_i) state_d = S_ACTIVE;
      S_ACTIVE: if (!busy && !(|prev_v_q) && !(|dfi_rddata_valid_o) && !(|dfi_rddata_en_i))
                  state_d = S_IDLE;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush_req) state_d = S_FLUSH;
  end

  // FSM: outputs
  always_comb begin
    clear_pipe = (state_q == S_FLUSH);
    cfg_open   = (state_q == S_IDLE);
  end

  // Configuration and sticky error; a set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdlat_q   <= '0;
      rdphase_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wr_ctrl && cfg_open) begin
        rdlat_q   <= lat_sat;
        rdphase_q <= csr_dat_w[8 +: PW];
      end
      if ((wr_ctrl && !cfg_open) || ovf)   err_q <= 1'b1;
      else if (wr_status && csr_dat_w[1]) err_q <= 1'b0;
    end
  end
  assign err_o = err_q;

  // Enable delay line; stage 0 is the registered input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MAX_LAT; i++) dline_q[i] <= '0;
    end else if (clear_pipe) begin
      for (int i = 0; i <= MAX_LAT; i++) dline_q[i] <= '0;
    end else begin
      dline_q[0] <= dfi_rddata_en_i;
      for (int i = 1; i <= MAX_LAT; i++) dline_q[i] <= dline_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= MAX_LAT; i++) busy = busy | (|dline_q[i]);
  end

  // Rotation: out[p] = {cur, prev}[NPHASES - k + p], which selects cur[p-k]
  // for p >= k and prev[NPHASES+p-k] for p < k.
  logic [NPHASES-1:0]   tap, rot_v;
  logic [2*NPHASES-1:0] cat_v;
  logic [2*NW-1:0]      cat_d;
  logic [NW-1:0]        rot_d, masked_d;
  logic [PW:0]          sh;
  logic [SW-1:0]        sh_d;

  assign tap   = dline_q[rdlat_q];
  assign sh    = (PW+1)'(NPHASES) - {1'b0, rdphase_q};
  assign sh_d  = SW'(sh) * SW'(DATA_W);
  assign cat_v = {tap, prev_v_q};
  assign cat_d = {phy_rddata_i, prev_d_q};
  assign rot_v = cat_v[sh +: NPHASES];
  assign rot_d = cat_d[sh_d +: NW];

  always_comb begin
    masked_d = '0;
    for (int p = 0; p < NPHASES; p++)
      if (rot_v[p]) masked_d[p*DATA_W +: DATA_W] = rot_d[p*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_v_q           <= '0;
      prev_d_q           <= '0;
      dfi_rddata_valid_o <= '0;
      dfi_rddata_o       <= '0;
    end else if (clear_pipe) begin
      prev_v_q           <= '0;
      prev_d_q           <= '0;
      dfi_rddata_valid_o <= '0;
      dfi_rddata_o       <= '0;
    end else begin
      prev_v_q           <= tap;
      prev_d_q           <= phy_rddata_i;
      dfi_rddata_valid_o <= rot_v;
      dfi_rddata_o       <= masked_d;
    end
  end

`ifdef DFI_RDLAT_STATS_EN
  logic        sel_stats, wr_stats;
  logic [31:0] stats_q;
  assign sel_stats = (csr_adr == CSR_BASE + 10'h008);
  assign wr_stats  = csr_we & sel_stats;
  // A valid about to be discarded by the flush counts as an overflow.
  assign ovf       = clear_pipe & (|rot_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stats_q <= '0;
    else if (wr_stats) stats_q <= '0;
    else               stats_q <= stats_q + 32'($countones(dfi_rddata_valid_o));
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    csr_dat_r = '0;
    if (sel_ctrl) begin
      csr_dat_r[LW-1:0]  = rdlat_q;
      csr_dat_r[8 +: PW] = rdphase_q;
    end else if (sel_status) begin
      csr_dat_r[1:0] = {err_q, busy};
    end
`ifdef DFI_RDLAT_STATS_EN
    else if (sel_stats) begin
      csr_dat_r = stats_q;
    end
`endif
  end

endmodule
